// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers,
// timing each frame and the idle gap after it from baud_tick pulses.

module uart_tx_sched_lane #(
    parameter int IDX  = 0,
    parameter int ID_W = 2
) (
    input  logic            req,
    input  logic [ID_W-1:0] last,
    output logic            req_hi
);
    // Requests strictly above the last winner get first pick; the rest wrap around.
    assign req_hi = req && (ID_W'(IDX) > last);
endmodule

module uart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int FRAME_BITS = 10,
    parameter int GAP_BITS   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [ID_W-1:0]      cur_id
);
    localparam int MAX_BITS = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          bit_cnt;
    logic [ID_W-1:0]           last;
    logic [NUM_REQ-1:0][7:0]   req_bytes;
    logic [NUM_REQ-1:0]        req_hi;
    logic [ID_W-1:0]           win_hi, win_lo, win;
    logic                      any_hi;

    assign req_bytes = req_data;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        uart_tx_sched_lane #(.IDX(i), .ID_W(ID_W)) u_lane (
            .req    (req[i]),
            .last   (last),
            .req_hi (req_hi[i])
        );
    end

    // Lowest index above last wins; otherwise lowest index overall (wrap).
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        any_hi = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_hi[i]) begin
                win_hi = ID_W'(i);
                any_hi = 1'b1;
            end
            if (req[i]) win_lo = ID_W'(i);
        end
        win = any_hi ? win_hi : win_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            last     <= ID_W'(NUM_REQ - 1);
            grant    <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            cur_id   <= '0;
        end else begin
            grant <= '0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        grant    <= NUM_REQ'(1) << win;
                        tx_data  <= req_bytes[win];
                        cur_id   <= win;
                        last     <= win;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (baud_tick) begin
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            tx_start <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= S_GAP;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (baud_tick) begin
                        if (bit_cnt == CNT_W'(GAP_BITS - 1)) begin
                            busy    <= 1'b0;
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
